// File: rtl/button_pkg.sv
// Shared types and constants for the button conditioner.
// Optional feature macro: BTN_AUTO_REPEAT_EN (enables auto-repeat pulses).
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    REPEAT   = 3'd3,
    REL_DB   = 3'd4
  } btn_state_t;

  localparam int DEF_PRESS_THR  = 500000;    // 10 ms @ 50 MHz
  localparam int DEF_LONG_THR   = 12500000;  // 250 ms
  localparam int DEF_REPEAT_THR = 2500000;   // 50 ms

  // Counter width covering the largest threshold, never below one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    int w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce/long/repeat FSM, registered events.
// Auto-repeat pulses exist only when BTN_AUTO_REPEAT_EN is defined.
module button_channel
  import button_pkg::*;
#(
  parameter int PRESS_THR  = DEF_PRESS_THR,
  parameter int LONG_THR   = DEF_LONG_THR,
  parameter int REPEAT_THR = DEF_REPEAT_THR,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press,
  output logic long_press,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic act
);

  localparam int CW = cnt_width(PRESS_THR, LONG_THR, REPEAT_THR);
  localparam logic [CW-1:0] PRESS_LAST = CW'(PRESS_THR - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_THR - 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST   = CW'(REPEAT_THR - 1);
`endif

  logic       sync1_reg, sync2_reg;
  logic       s;
  btn_state_t state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic press_reg, press_next;
  logic long_reg, long_next;
  logic rep_reg, rep_next;
  logic rel_reg, rel_next;
  logic level_reg, level_next;
  logic act_reg, act_next;

  assign s = sync2_reg ^ ACTIVE_LOW;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    press_next = 1'b0;
    long_next  = 1'b0;
    rep_next   = 1'b0;
    rel_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (s) begin
          state_next = PRESS_DB;
          cnt_next   = '0;
        end
      end
      PRESS_DB: begin
        if (!s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == PRESS_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_next = REL_DB;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          state_next = REPEAT;
          cnt_next   = '0;
          long_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_next = REL_DB;
          cnt_next   = '0;
        end else begin
`ifdef BTN_AUTO_REPEAT_EN
          if (cnt_reg == REP_LAST) begin
            cnt_next = '0;
            rep_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
`else
          cnt_next = '0;
`endif
        end
      end
      REL_DB: begin
        // A bounce back to pressed returns to HELD with the long timer restarted.
        if (s) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt_reg == PRESS_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
          rel_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    level_next = state_next inside {HELD, REPEAT, REL_DB};
    act_next   = press_next | long_next | rep_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= ACTIVE_LOW;
      sync2_reg <= ACTIVE_LOW;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      press_reg <= 1'b0;
      long_reg  <= 1'b0;
      rep_reg   <= 1'b0;
      rel_reg   <= 1'b0;
      level_reg <= 1'b0;
      act_reg   <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      press_reg <= press_next;
      long_reg  <= long_next;
      rep_reg   <= rep_next;
      rel_reg   <= rel_next;
      level_reg <= level_next;
      act_reg   <= act_next;
    end
  end

  assign level         = level_reg;
  assign press         = press_reg;
  assign long_press    = long_reg;
  assign repeat_pulse  = rep_reg;
  assign release_pulse = rel_reg;
  assign act           = act_reg;

endmodule

// File: rtl/button_conditioner.sv
// N-channel button front end: one independent button_channel per input bit.
// Define BTN_AUTO_REPEAT_EN to enable auto-repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N          = 4,
  parameter int PRESS_THR  = DEF_PRESS_THR,
  parameter int LONG_THR   = DEF_LONG_THR,
  parameter int REPEAT_THR = DEF_REPEAT_THR,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] act
);

  for (genvar gi = 0; gi < N; gi++) begin : g_ch
    button_channel #(
      .PRESS_THR (PRESS_THR),
      .LONG_THR  (LONG_THR),
      .REPEAT_THR(REPEAT_THR),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .raw          (in[gi]),
      .level        (level[gi]),
      .press        (press[gi]),
      .long_press   (long_press[gi]),
      .repeat_pulse (repeat_pulse[gi]),
      .release_pulse(release_pulse[gi]),
      .act          (act[gi])
    );
  end

endmodule
